brightness_scheduler: RTL
=========================

Name: brightness_scheduler

Overview:
Controller between the debounced encoder-step logic and the shared PWM generator bank. Converts increment, decrement and channel-select strobes into per-channel brightness values. It owns the brightness register for each LED channel, queues steps that arrive while the PWM write port is busy, and sequences every update onto a single valid/ready write port. After reset it initialises all PWM channels to zero before accepting user steps.

Parameters:
PWM_VALUE_SIZE, 8, width of one brightness value; range 0..2^PWM_VALUE_SIZE-1
BRIGHTNESS_INC, 5, step added or subtracted per encoder detent; must be >=1 and < 2^PWM_VALUE_SIZE
CHANNELS, 4, number of LED/PWM channels; must be >=2
PEND_W, 4, width of the signed pending-step counter; range is ±(2^(PEND_W-1)-1)

Ports:
clk_i  in  1  system clock; only clock
rst_n_i  in  1  synchronous active-low reset
inc_stb_i  in  1  one-cycle strobe: one step clockwise
dec_stb_i  in  1  one-cycle strobe: one step counter-clockwise
sel_stb_i  in  1  one-cycle strobe: advance to the next channel
pwm_wr_valid_o  out  1  write request to the PWM bank
pwm_wr_ready_i  in  1  PWM bank accepts the write on valid&&ready
pwm_wr_ch_o  out  $clog2(CHANNELS)  channel index of the write
pwm_wr_value_o  out  PWM_VALUE_SIZE  brightness value of the write
sel_ch_o  out  $clog2(CHANNELS)  currently selected channel
busy_o  out  1  high whenever state != IDLE or pending != 0

Behaviour:
- One clock (clk_i). Reset is synchronous and active-low (rst_n_i), sampled on the rising edge of clk_i.
- Reset values:
  - valid = 0, ch = 0, value = 0
  - sel_ch_o = 0, pending = 0, sel_req = 0
  - all brightness registers = 0
  - state = INIT, init index = 0
  - busy_o = 1
- Reset asserted mid-operation aborts any in-flight write immediately; no commit occurs.
- Pending counter update, every cycle:
  - inc only: +1
  - dec only: -1
  - inc and dec together: no change
  - Saturates at ±(2^(PEND_W-1)-1); excess steps are dropped.
  - Updated in every state, so strobes are never lost during INIT or WRITE.
- sel_stb_i sets sel_req.
  - In IDLE with sel_req=1: pending is cleared, sel_ch_o increments modulo CHANNELS, sel_req is cleared, and no write is issued that cycle.
  - An inc/dec strobe in the same cycle as that IDLE-side sel action counts toward the new channel, i.e. pending becomes ±1 rather than 0.
  - A write already in flight always completes on its original channel.
- State INIT:
  - Issues write (ch = idx, value = 0) per channel with valid/ready handshake.
  - idx advances on each handshake.
  - After channel CHANNELS-1 is accepted, go to IDLE.
- State IDLE (sel_req = 0, pending != 0):
  - Compute nv = bright[sel] + BRIGHTNESS_INC if pending>0, else bright[sel] - BRIGHTNESS_INC, in PWM_VALUE_SIZE+1 bits.
  - Clamp nv to [0, 2^PWM_VALUE_SIZE-1].
  - pending moves one toward zero.
  - If nv == bright[sel] (already at limit): no write, remain IDLE.
  - Otherwise: load ch = sel, value = nv, valid = 1, go to WRITE.
- State WRITE:
  - valid, ch and value are held stable until pwm_wr_ready_i = 1.
  - On handshake: bright[ch] = value, valid = 0 on the next edge, go to IDLE.
- Latency: from a strobe sampled at edge N with the block IDLE and pending 0, valid is high after edge N+1. With ready held at 1, the next step can be issued 2 cycles after a handshake.
- pwm_wr_ready_i is ignored while valid = 0.

Decomposition:
- Shared package: state encoding (INIT, IDLE, WRITE) and helper constant CH_W = $clog2(CHANNELS).
- Sub-module step_accumulator: signed saturating pending counter with inc, dec, clear and consume inputs, parameterised by PEND_W.
- Clamp arithmetic stays inline.

Test Plan:
- Reset, ready=1 -> exactly 4 writes (ch 0..3, value 0) on consecutive handshakes; busy_o then drops to 0; sel_ch_o = 0.
- After init, one inc_stb, ready=1 -> single write ch=0 value=5; valid high 1 cycle after the strobe cycle.
- 52 inc_stb spaced 4 cycles apart -> 51 writes ending at 255; 52nd produces no write. Then dec_stb with bright=0 on ch1 -> no write.
- Ready held 0 for 10 cycles during a write -> valid/ch/value stable; 3 further incs queue (pending=3). After ready=1 -> values 10, 15, 20 written in order.
- inc_stb and dec_stb in the same cycle -> no write, pending stays 0.
- Ready low, write of 5 in flight, 2 queued incs, then sel_stb -> write 5 on ch0 completes, queued steps discarded, sel_ch_o = 1. Following inc -> write ch=1 value=5.

Source files
------------

// File: rtl/brightness_scheduler_pkg.sv
// Shared types and constants for the brightness scheduler: FSM state encoding
// and the default channel-index width.
package brightness_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   localparam int CHANNELS_DEF = 4;
   localparam int CH_W         = $clog2(CHANNELS_DEF);

endpackage

// File: rtl/brightness_scheduler_step_accumulator.sv
// Signed saturating count of encoder steps not yet turned into PWM writes.
// clear drops the backlog; consume moves it one step toward zero.
module step_accumulator #(
   parameter int PEND_W = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     inc_i,
   input  logic                     dec_i,
   input  logic                     clear_i,
   input  logic                     consume_i,
   output logic signed [PEND_W-1:0] pending_o
);

   localparam int SUM_W = PEND_W + 2;
   localparam int LIM_I = (2 ** (PEND_W - 1)) - 1;

   logic signed [SUM_W-1:0] lim_pos;
   logic signed [SUM_W-1:0] lim_neg;
   logic signed [SUM_W-1:0] base;
   logic signed [SUM_W-1:0] delta;
   logic signed [SUM_W-1:0] toward;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] sat;

   assign lim_pos = SUM_W'(LIM_I);
   assign lim_neg = -lim_pos;

   always_comb begin
      delta  = '0;
      toward = '0;
      base   = '0;
      sat    = '0;
      if (inc_i && !dec_i) begin
         delta = SUM_W'(1);
      end else if (dec_i && !inc_i) begin
         delta = '1;
      end
      // A strobe in the same cycle as a clear counts toward the fresh backlog.
      if (!clear_i) begin
         base = {{2{pending_o[PEND_W-1]}}, pending_o};
         if (consume_i && (pending_o != '0)) begin
            toward = pending_o[PEND_W-1] ? SUM_W'(1) : '1;
         end
      end
      sum = base + delta + toward;
      if (sum > lim_pos) begin
         sat = lim_pos;
      end else if (sum < lim_neg) begin
         sat = lim_neg;
      end else begin
         sat = sum;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pending_o <= '0;
      end else begin
         pending_o <= sat[PEND_W-1:0];
      end
   end

endmodule

// File: rtl/brightness_scheduler.sv
// Turns encoder inc/dec/select strobes into per-channel brightness updates and
// sequences them, after a zeroing pass over all channels, onto one PWM write port.
module brightness_scheduler
   import brightness_scheduler_pkg::*;
#(
   parameter int PWM_VALUE_SIZE = 8,
   parameter int BRIGHTNESS_INC = 5,
   parameter int CHANNELS       = CHANNELS_DEF,
   parameter int PEND_W         = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        inc_stb_i,
   input  logic                        dec_stb_i,
   input  logic                        sel_stb_i,
   output logic                        pwm_wr_valid_o,
   input  logic                        pwm_wr_ready_i,
   output logic [$clog2(CHANNELS)-1:0] pwm_wr_ch_o,
   output logic [PWM_VALUE_SIZE-1:0]   pwm_wr_value_o,
   output logic [$clog2(CHANNELS)-1:0] sel_ch_o,
   output logic                        busy_o
);

   // Write port: valid rises with ch/value loaded; all three stay frozen until
   // the cycle valid && ready, which is the one and only transfer edge.
   localparam int SEL_W = $clog2(CHANNELS);
   localparam int VW    = PWM_VALUE_SIZE;
   localparam logic [VW:0]    INC_X = (VW + 1)'(BRIGHTNESS_INC);
   localparam logic [VW-1:0]  VMAX  = '1;
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

   state_t                    state;
   logic [SEL_W-1:0]          init_idx;
   logic                      sel_req;
   logic [VW-1:0]             bright [CHANNELS];
   logic signed [PEND_W-1:0]  pending;

   logic                      sel_act;
   logic                      step_act;
   logic [VW-1:0]             cur;
   logic [VW:0]               up_x;
   logic [VW:0]               dn_x;
   logic [VW-1:0]             nv;

   assign sel_act  = (state == ST_IDLE) && sel_req;
   assign step_act = (state == ST_IDLE) && !sel_req && (pending != '0);
   assign cur      = bright[sel_ch_o];
   assign busy_o   = (state != ST_IDLE) || (pending != '0);

   always_comb begin
      up_x = {1'b0, cur} + INC_X;
      dn_x = {1'b0, cur} - INC_X;
      nv   = cur;
      // The extra top bit flags overflow on the way up and borrow on the way down.
      if (!pending[PEND_W-1]) begin
         nv = up_x[VW] ? VMAX : up_x[VW-1:0];
      end else begin
         nv = dn_x[VW] ? '0 : dn_x[VW-1:0];
      end
   end

   step_accumulator #(
      .PEND_W (PEND_W)
   ) u_step_acc (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .inc_i     (inc_stb_i),
      .dec_i     (dec_stb_i),
      .clear_i   (sel_act),
      .consume_i (step_act),
      .pending_o (pending)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state          <= ST_INIT;
         init_idx       <= '0;
         sel_req        <= 1'b0;
         sel_ch_o       <= '0;
         pwm_wr_valid_o <= 1'b0;
         pwm_wr_ch_o    <= '0;
         pwm_wr_value_o <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            bright[i] <= '0;
         end
      end else begin
         if (sel_stb_i) begin
            sel_req <= 1'b1;
         end else if (sel_act) begin
            sel_req <= 1'b0;
         end

         case (state)
            ST_INIT: begin
               if (!pwm_wr_valid_o) begin
                  pwm_wr_valid_o <= 1'b1;
                  pwm_wr_ch_o    <= init_idx;
                  pwm_wr_value_o <= '0;
               end else if (pwm_wr_ready_i) begin
                  bright[pwm_wr_ch_o] <= pwm_wr_value_o;
                  if (init_idx == LAST_CH) begin
                     pwm_wr_valid_o <= 1'b0;
                     state          <= ST_IDLE;
                  end else begin
                     init_idx    <= init_idx + 1'b1;
                     pwm_wr_ch_o <= init_idx + 1'b1;
                  end
               end
            end

            ST_IDLE: begin
               if (sel_req) begin
                  sel_ch_o <= (sel_ch_o == LAST_CH) ? '0 : sel_ch_o + 1'b1;
               end else if ((pending != '0) && (nv != cur)) begin
                  pwm_wr_ch_o    <= sel_ch_o;
                  pwm_wr_value_o <= nv;
                  pwm_wr_valid_o <= 1'b1;
                  state          <= ST_WRITE;
               end
            end

            ST_WRITE: begin
               if (pwm_wr_ready_i) begin
                  bright[pwm_wr_ch_o] <= pwm_wr_value_o;
                  pwm_wr_valid_o      <= 1'b0;
                  state               <= ST_IDLE;
               end
            end

            default: begin
               pwm_wr_valid_o <= 1'b0;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
